// File: rtl/x_byte_pkg.sv
// x_byte_pkg: shared definitions for the x_byte command protocol
// (serializer and deserializer).
package x_byte_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        APPLY
    } state_t;

    // Write command layout: {1'b1, value, index[5:0]}.
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_DATA_BIT = 6;
    localparam int unsigned IDX_W        = 6;

    // Bit 7 clear, so it can never alias a write command.
    localparam logic [7:0] DEFAULT_APPLY_CMD = 8'h00;

    // Build a write command for one bit of the word.
    function automatic logic [7:0] f_wr_cmd(input logic value, input logic [IDX_W-1:0] index);
        logic [7:0] cmd;
        cmd               = 8'(index);
        cmd[CMD_WR_BIT]   = 1'b1;
        cmd[CMD_DATA_BIT] = value;
        return cmd;
    endfunction

endpackage

// File: rtl/x_byte_ser.sv
// x_byte_ser: serializes a WIDTH-bit word into one write command per bit
// followed by an apply command, so the far end updates the word atomically.
// Optional macro X_BYTE_SER_DIFF_EN: only bits that differ from the last
// applied word are written; the apply command is always sent.
module x_byte_ser
    import x_byte_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter logic [7:0]  APPLY_CMD = DEFAULT_APPLY_CMD
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_cmd,
    output logic             o_busy
);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   shadow_q;

    logic [IDX_W-1:0]   idx_nxt;
    logic               idx_last;
    logic               nxt_bit;
    logic               first_vld;
    logic               nxt_vld;
    logic               advance;

`ifdef X_BYTE_SER_DIFF_EN
    logic [WIDTH-1:0]   sent_q;

    // Skip bits already held by the far end; skipped indices step without i_ready.
    always_comb begin
        first_vld = i_data[0] ^ sent_q[0];
        nxt_vld   = shadow_q[idx_nxt] ^ sent_q[idx_nxt];
        advance   = i_ready | ~o_valid;
    end

    // Track the word the far end holds after the last apply.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sent_q <= '0;
        end else if (state_q == APPLY && i_ready) begin
            sent_q <= shadow_q;
        end
    end
`else
    // Every bit is written, so each index waits for a handshake.
    always_comb begin
        first_vld = 1'b1;
        nxt_vld   = 1'b1;
        advance   = i_ready;
    end
`endif

    // Next index and the bit it selects, used to preload the registered command.
    always_comb begin
        idx_nxt  = idx_q + 1'b1;
        idx_last = (idx_q == IDX_W'(WIDTH - 1));
        nxt_bit  = shadow_q[idx_nxt];
    end

    // FSM with registered outputs: each output is loaded with its next-state value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_cmd    <= 8'h00;
            o_busy   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        shadow_q <= i_data;
                        idx_q    <= '0;
                        state_q  <= WRITE;
                        o_valid  <= first_vld;
                        o_cmd    <= f_wr_cmd(i_data[0], '0);
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (advance) begin
                        if (idx_last) begin
                            state_q <= APPLY;
                            o_valid <= 1'b1;
                            o_cmd   <= APPLY_CMD;
                        end else begin
                            idx_q   <= idx_nxt;
                            o_valid <= nxt_vld;
                            o_cmd   <= f_wr_cmd(nxt_bit, idx_nxt);
                        end
                    end
                end
                APPLY: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        o_valid <= 1'b0;
                        o_cmd   <= 8'h00;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_byte_ser.sv
// tb_x_byte_ser: directed bench for x_byte_ser with a behavioural far-end
// deserializer model. Build with X_BYTE_SER_DIFF_EN to exercise the diff mode.
module tb_x_byte_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [63:0] i_data = '0;
    logic        o_ready;
    logic        o_valid;
    logic        o_busy;
    logic [7:0]  o_cmd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [7:0]  q_cmd[$];
    int          q_cyc[$];
    logic [63:0] pend = '0;
    logic [63:0] des_out = '0;
    int          des_cnt = 0;
    int          stall_err = 0;
    logic        stalled = 1'b0;
    logic [7:0]  stall_cmd = '0;

    x_byte_ser #(
        .WIDTH     (64),
        .APPLY_CMD (8'h00)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_cmd   (o_cmd),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: always, 1-0-0 repeating, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       i_ready = (cyc % 3 == 0);
            2:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b1;
        endcase
    end

    // Byte log, stall stability watch and far-end deserializer model.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
            pend    = '0;
            des_out = '0;
        end else begin
            if (stalled && (o_cmd !== stall_cmd || o_valid !== 1'b1)) stall_err++;
            stalled   = o_valid && !i_ready;
            stall_cmd = o_cmd;
            if (o_valid && i_ready) begin
                q_cmd.push_back(o_cmd);
                q_cyc.push_back(cyc);
                if (o_cmd[7]) begin
                    pend[o_cmd[5:0]] = o_cmd[6];
                end else begin
                    des_out = pend;
                    des_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [63:0] w);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = w;
        while (!o_ready && n < 500) begin
            tick();
            n++;
        end
        check("accept_wait", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        i_data  = ~w;
    endtask

    task automatic wait_apply(input int prev);
        int n;
        n = 0;
        while (des_cnt == prev && n < 2000) begin
            tick();
            n++;
        end
        check("apply_seen", 64'(des_cnt), 64'(prev + 1));
    endtask

    // Expected byte k for a word whose only set bits are listed in the tag.
    function automatic logic [7:0] exp_a(input int k);
        if (k == 0) return 8'hC0;
        if (k == 63) return 8'hFF;
        if (k == 64) return 8'h00;
        return 8'h80 | 8'(k);
    endfunction

    function automatic logic [7:0] exp_b(input int k);
        if (k == 1) return 8'hC1;
        if (k == 64) return 8'h00;
        return 8'h80 | 8'(k);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        int n;
        int prev;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Idle after reset.
        repeat (5) tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_cmd", 64'(o_cmd), 64'h00);

`ifndef X_BYTE_SER_DIFF_EN
        // Full word, i_ready held high.
        q_cmd.delete(); q_cyc.delete();
        rdy_mode = 0;
        prev = des_cnt;
        send_word(64'h8000_0000_0000_0001);
        check("busy_ready", 64'(o_ready), 64'd0);
        check("busy_flag", 64'(o_busy), 64'd1);
        wait_apply(prev);
        check("ready_after_apply", 64'(o_ready), 64'd1);
        check("idle_after_apply", 64'(o_busy), 64'd0);
        check("seq_len", 64'(q_cmd.size()), 64'd65);
        if (q_cmd.size() == 65) begin
            for (int k = 0; k < 65; k++) check($sformatf("seq_a[%0d]", k), 64'(q_cmd[k]), 64'(exp_a(k)));
            check("seq_back_to_back", 64'(q_cyc[64] - q_cyc[0]), 64'd64);
        end
        check("des_word_a", des_out, 64'h8000_0000_0000_0001);

        // Same word under 1-0-0 backpressure.
        q_cmd.delete(); q_cyc.delete();
        stall_err = 0;
        rdy_mode = 1;
        prev = des_cnt;
        send_word(64'h8000_0000_0000_0001);
        wait_apply(prev);
        check("bp_len", 64'(q_cmd.size()), 64'd65);
        if (q_cmd.size() == 65) begin
            for (int k = 0; k < 65; k++) check($sformatf("bp_a[%0d]", k), 64'(q_cmd[k]), 64'(exp_a(k)));
        end
        check("bp_stall_stable", 64'(stall_err), 64'd0);

        // Second word offered while busy.
        repeat (2) tick();
        q_cmd.delete(); q_cyc.delete();
        rdy_mode = 0;
        prev = des_cnt;
        send_word(64'h8000_0000_0000_0001);
        i_valid = 1'b1;
        i_data  = 64'h2;
        n = 0;
        while (!o_ready && n < 500) begin
            tick();
            n++;
            if (n == 5) check("held_off", 64'(o_ready), 64'd0);
        end
        check("b_accept_after_apply", 64'(q_cmd.size()), 64'd65);
        check("des_word_a2", des_out, 64'h8000_0000_0000_0001);
        tick();
        i_valid = 1'b0;
        wait_apply(prev + 1);
        check("ab_len", 64'(q_cmd.size()), 64'd130);
        if (q_cmd.size() == 130) begin
            for (int k = 0; k < 65; k++) check($sformatf("ab_a[%0d]", k), 64'(q_cmd[k]), 64'(exp_a(k)));
            for (int k = 0; k < 65; k++) check($sformatf("ab_b[%0d]", k), 64'(q_cmd[65 + k]), 64'(exp_b(k)));
        end
        check("des_word_b", des_out, 64'h2);
`else
        // Diff mode: only changed bits are written.
        rdy_mode = 0;
        q_cmd.delete(); q_cyc.delete();
        prev = des_cnt;
        send_word(64'h0);
        wait_apply(prev);
        check("diff0_len", 64'(q_cmd.size()), 64'd1);
        if (q_cmd.size() >= 1) check("diff0_apply", 64'(q_cmd[0]), 64'h00);

        q_cmd.delete(); q_cyc.delete();
        prev = des_cnt;
        send_word(64'h10);
        wait_apply(prev);
        check("diff1_len", 64'(q_cmd.size()), 64'd2);
        if (q_cmd.size() >= 2) begin
            check("diff1_wr", 64'(q_cmd[0]), 64'hC4);
            check("diff1_apply", 64'(q_cmd[1]), 64'h00);
        end
        check("diff1_des", des_out, 64'h10);

        q_cmd.delete(); q_cyc.delete();
        prev = des_cnt;
        send_word(64'h0);
        wait_apply(prev);
        check("diff2_len", 64'(q_cmd.size()), 64'd2);
        if (q_cmd.size() >= 2) begin
            check("diff2_wr", 64'(q_cmd[0]), 64'h84);
            check("diff2_apply", 64'(q_cmd[1]), 64'h00);
        end
        check("diff2_des", des_out, 64'h0);
`endif

        // Reset in the middle of a word, at index 10.
        repeat (2) tick();
        q_cmd.delete(); q_cyc.delete();
        rdy_mode = 0;
        prev = des_cnt;
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        n = 0;
        while (q_cmd.size() < 10 && n < 500) begin
            tick();
            n++;
        end
        check("mid_cmd", 64'(o_cmd), 64'hCA);
        check("mid_valid", 64'(o_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_busy", 64'(o_busy), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_bytes", 64'(q_cmd.size()), 64'd10);
        check("abort_no_apply", 64'(des_cnt), 64'(prev));

        // Random words through the far-end model with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            prev = des_cnt;
            send_word(w);
            wait_apply(prev);
            check($sformatf("loop_word[%0d]", i), des_out, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
